neg_serial_unit: RTL and testbench
==================================

// Module: neg_serial_unit
// PURPOSE
//  Multi-cycle, width-parametrised unary ALU unit: NOT, NEG (2's complement), ABS, MOV.
//  Processes DIGIT bits per cycle LSB-first with a registered carry, trading latency for area.
//  Sits beside the combinational ALU. The control unit launches an operation with start
//  and stalls until the one-cycle done pulse.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  DIGIT  8   bits processed per cycle. WIDTH % DIGIT must be 0; elaboration error otherwise.
//  Derived: NSLICE = WIDTH/DIGIT (number of RUN cycles).
// PORTS
//  clk    in   1            single clock, all state updates on the rising edge
//  clr    in   1            reset, synchronous, active-low
//  start  in   1            launch request, sampled only when not busy
//  mode   in   2            00 NOT, 01 NEG, 10 ABS, 11 MOV (pass-through)
//  rA     in   WIDTH        operand, sampled on the accepted start edge only
//  busy   out  1            operation in progress
//  done   out  1            one-cycle pulse, rZ/ovf valid
//  rZ     out  WIDTH        result, held until the next accepted start or clr
//  ovf    out  1            NEG/ABS of the most-negative value (10..0). Valid with rZ.
// BEHAVIOUR
//  Reset (clr=0 at an edge): state<=IDLE. busy, done, ovf, rZ, slice index, carry all <= 0.
//   clr has priority over every other input, including in the middle of RUN.
//  FSM IDLE -> RUN -> DONE:
//   IDLE: start=1 -> latch rA into opnd, set inv/carry, compute ovf, idx<=0, go to RUN.
//   RUN: one slice per cycle.
//    res[idx] <= (opnd[idx] ^ {DIGIT{inv}}) + carry.
//    carry <= carry-out of that slice. idx++.
//    After slice NSLICE-1, go to DONE.
//   DONE: done=1 for exactly this cycle.
//    start=1 here is accepted: same actions as in IDLE, go straight to RUN.
//    Otherwise go to IDLE.
//  Mode setup at the accepted start:
//   NOT: inv=1, carry=0.  NEG: inv=1, carry=1.
//   ABS: inv=rA[WIDTH-1], carry=rA[WIDTH-1].  MOV: inv=0, carry=0.
//  ovf = (mode==NEG or ABS) && rA=={1'b1,{WIDTH-1{1'b0}}}. rZ then equals rA (wraps).
//  The final carry-out is discarded, e.g. NEG 0 = 0.
//  Latency: start accepted at edge t. busy=1 for cycles t+1..t+NSLICE. done=1 in cycle t+NSLICE+1.
//   busy=0 in the DONE cycle.
//  start while busy (RUN) is ignored and not queued. mode/rA changes during RUN have no effect.
//  rZ is updated slice-by-slice in a working register. The visible rZ is loaded only on the
//   RUN->DONE transition, so rZ never shows a partial result.
// STRUCTURE
//  Shared package cpu_alu_pkg:
//   mode constants UOP_NOT=2'b00, UOP_NEG=2'b01, UOP_ABS=2'b10, UOP_MOV=2'b11
//   state enum {IDLE, RUN, DONE}
//  Sub-module add_digit: DIGIT-bit ripple adder (a, b, cIn -> S, cOut).
//   Instantiated once, with b=0 and cIn=carry.
//  Top level holds the FSM, the opnd/work/rZ registers, idx, the carry flop and the ovf compare.
// TESTING (WIDTH=32, DIGIT=8, NSLICE=4)
//  NEG 0x00000005 at edge t -> busy t+1..t+4. done=1 only at t+5. rZ=0xFFFFFFFB, ovf=0.
//  NEG 0x80000000 -> rZ=0x80000000, ovf=1. NEG 0x00000000 -> rZ=0, ovf=0.
//  ABS 0xFFFFFF9C -> 0x00000064. ABS 0x00000064 -> 0x00000064. NOT 0x0F0F0F0F -> 0xF0F0F0F0.
//   MOV 0xDEADBEEF -> 0xDEADBEEF.
//  Pulse start again at t+2 with rA=0x1 -> ignored. Result is still that of the first op.
//   Exactly one done pulse.
//  start held high through DONE -> back-to-back op. done pulses at t+5 and t+10.
//   rZ holds the first result until t+10.
//  clr=0 at t+3 mid-RUN -> busy=done=ovf=0 and rZ=0 the next cycle.
//   No done pulse follows. A new start afterwards completes normally.

Source files
------------

// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the serial unary ALU unit: operation codes and FSM states.
package cpu_alu_pkg;

    localparam logic [1:0] UOP_NOT = 2'b00;
    localparam logic [1:0] UOP_NEG = 2'b01;
    localparam logic [1:0] UOP_ABS = 2'b10;
    localparam logic [1:0] UOP_MOV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/neg_serial_unit_add_digit.sv
// DIGIT-bit ripple-carry adder used for one slice of the serial datapath.
module add_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cIn,
    output logic [DIGIT-1:0] S,
    output logic             cOut
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = cIn;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            S[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cOut = c[DIGIT];

endmodule

// File: rtl/neg_serial_unit.sv
// Multi-cycle unary ALU (NOT/NEG/ABS/MOV) processing DIGIT bits per cycle, LSB first.
module neg_serial_unit
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] rA,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rZ,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("neg_serial_unit: WIDTH must be a multiple of DIGIT");
    end

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              inv_q, inv_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [WIDTH-1:0]  rz_q, rz_d;
    logic              ovf_q, ovf_d;
    logic              ovf_pend_q, ovf_pend_d;

    logic [DIGIT-1:0]  slice_sum;
    logic              slice_cout;

    // opnd shifts right each RUN cycle so the active slice is always its low DIGIT bits
    add_digit #(.DIGIT(DIGIT)) u_add (
        .a    (opnd_q[DIGIT-1:0] ^ {DIGIT{inv_q}}),
        .b    ('0),
        .cIn  (carry_q),
        .S    (slice_sum),
        .cOut (slice_cout)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        inv_d      = inv_q;
        opnd_d     = opnd_q;
        work_d     = work_q;
        rz_d       = rz_q;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;

        case (state_q)
            RUN: begin
                opnd_d  = opnd_q >> DIGIT;
                work_d  = WIDTH'({slice_sum, work_q} >> DIGIT);
                carry_d = slice_cout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NSLICE - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                    rz_d    = work_d;
                    ovf_d   = ovf_pend_q;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d    = RUN;
                    opnd_d     = rA;
                    work_d     = '0;
                    idx_d      = '0;
                    ovf_pend_d = ((mode == UOP_NEG) || (mode == UOP_ABS)) && (rA == MOST_NEG);
                    case (mode)
                        UOP_NOT: begin inv_d = 1'b1;        carry_d = 1'b0;        end
                        UOP_NEG: begin inv_d = 1'b1;        carry_d = 1'b1;        end
                        UOP_ABS: begin inv_d = rA[WIDTH-1]; carry_d = rA[WIDTH-1]; end
                        default: begin inv_d = 1'b0;        carry_d = 1'b0;        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            inv_q      <= 1'b0;
            opnd_q     <= '0;
            work_q     <= '0;
            rz_q       <= '0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            inv_q      <= inv_d;
            opnd_q     <= opnd_d;
            work_q     <= work_d;
            rz_q       <= rz_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign rZ   = rz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_neg_serial_unit.sv
// Self-checking bench for neg_serial_unit (WIDTH=32, DIGIT=8).
module tb_neg_serial_unit;
    import cpu_alu_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] rA;
    logic        busy, done, ovf;
    logic [31:0] rZ;

    int n_checks = 0;
    int n_fail   = 0;

    neg_serial_unit #(.WIDTH(32), .DIGIT(8)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .mode  (mode),
        .rA    (rA),
        .busy  (busy),
        .done  (done),
        .rZ    (rZ),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] a;
        logic [31:0] z;
        logic        o;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the whole word, {ovf, result}
    function automatic logic [32:0] model(input logic [1:0] m, input logic [31:0] a);
        logic [31:0] z;
        logic        o;
        case (m)
            UOP_NOT: z = ~a;
            UOP_NEG: z = 32'd0 - a;
            UOP_ABS: z = ($signed(a) < 0) ? 32'd0 - a : a;
            default: z = a;
        endcase
        o = ((m == UOP_NEG) || (m == UOP_ABS)) && (a == 32'h8000_0000);
        return {o, z};
    endfunction

    task automatic run_op(input logic [1:0] m, input logic [31:0] a,
                          input logic [31:0] ez, input logic eo, input string nm);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; mode = m; rA = a;
        @(negedge clk);
        start = 1'b0; mode = 2'($urandom); rA = $urandom;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, lat, 5);
        check({nm, " busy cycles"}, busy_cnt, 4);
        check({nm, " busy in done"}, {31'd0, busy}, 0);
        check({nm, " rZ"}, rZ, ez);
        check({nm, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        @(negedge clk);
        check({nm, " done single"}, {31'd0, done}, 0);
    endtask

    initial begin
        logic [32:0] r;
        int          dcnt;
        int          dk[$];

        vecs[0] = '{UOP_NEG, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0};
        vecs[1] = '{UOP_NEG, 32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[2] = '{UOP_NEG, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{UOP_ABS, 32'hFFFF_FF9C, 32'h0000_0064, 1'b0};
        vecs[4] = '{UOP_ABS, 32'h0000_0064, 32'h0000_0064, 1'b0};
        vecs[5] = '{UOP_NOT, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0};
        vecs[6] = '{UOP_MOV, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};

        clr = 1'b0; start = 1'b0; mode = '0; rA = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset ovf",  {31'd0, ovf}, 0);
        check("reset rZ",   rZ, 0);
        clr = 1'b1;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].m, vecs[i].a, vecs[i].z, vecs[i].o, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  m;
            logic [31:0] a;
            m = 2'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'h0;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            r = model(m, a);
            run_op(m, a, r[31:0], r[32], $sformatf("rnd%0d", i));
        end

        // start pulsed during RUN is dropped
        @(negedge clk);
        start = 1'b1; mode = UOP_NEG; rA = 32'h5;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; rA = 32'h1; mode = UOP_MOV;
        @(negedge clk); start = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        check("ignore done count", dcnt, 1);
        check("ignore rZ", rZ, 32'hFFFF_FFFB);

        // start held high through DONE gives a back-to-back op
        start = 1'b1; mode = UOP_MOV; rA = 32'h1111_1111;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin mode = UOP_NOT; rA = 32'h2222_2222; end
            if (k == 6) start = 1'b0;
            if (done) dk.push_back(k);
            if (k == 9) check("b2b rZ held", rZ, 32'h1111_1111);
            if (k == 10) check("b2b rZ second", rZ, 32'hDDDD_DDDD);
        end
        check("b2b done pulses", dk.size(), 2);
        if (dk.size() == 2) begin
            check("b2b first done", dk[0], 5);
            check("b2b second done", dk[1], 10);
        end

        // clr mid-RUN aborts the op; ovf and rZ were nonzero beforehand
        run_op(UOP_NEG, 32'h8000_0000, 32'h8000_0000, 1'b1, "pre-clr");
        start = 1'b1; mode = UOP_NEG; rA = 32'h5;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        check("clr busy", {31'd0, busy}, 0);
        check("clr done", {31'd0, done}, 0);
        check("clr ovf",  {31'd0, ovf}, 0);
        check("clr rZ",   rZ, 0);
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        check("clr no done", dcnt, 0);
        run_op(UOP_ABS, 32'hFFFF_FF9C, 32'h0000_0064, 1'b0, "post-clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
